// File: rtl/cpu_controller_pkg.sv
// rtl/cpu_controller_pkg.sv - state, opcode and select encodings for the CPU control sequencer
package cpu_ctrl_pkg;

  localparam int CODE_W = 11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [CODE_W-1:0] ALU_ADD  = 11'd0;
  localparam logic [CODE_W-1:0] ALU_ADDI = 11'd1;
  localparam logic [CODE_W-1:0] ALU_SUB  = 11'd2;
  localparam logic [CODE_W-1:0] ALU_RSB  = 11'd3;
  localparam logic [CODE_W-1:0] ALU_AND  = 11'd4;
  localparam logic [CODE_W-1:0] ALU_ORR  = 11'd5;
  localparam logic [CODE_W-1:0] ALU_EOR  = 11'd6;
  localparam logic [CODE_W-1:0] ALU_BIC  = 11'd7;
  localparam logic [CODE_W-1:0] ALU_CMP  = 11'd8;
  localparam logic [CODE_W-1:0] ALU_CMN  = 11'd9;
  localparam logic [CODE_W-1:0] ALU_TST  = 11'd10;
  localparam logic [CODE_W-1:0] ALU_MOV  = 11'd11;
  localparam logic [CODE_W-1:0] ALU_MOVI = 11'd12;
  localparam logic [CODE_W-1:0] ALU_CMPI = 11'd13;
  localparam logic [CODE_W-1:0] BR_B     = 11'd31;
  localparam logic [CODE_W-1:0] BR_BL    = 11'd32;
  localparam logic [CODE_W-1:0] DT_LDR   = 11'd41;
  localparam logic [CODE_W-1:0] DT_STR   = 11'd42;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;

  // Data-processing ops that finish with a register writeback.
  function automatic logic is_alu_wb(input logic [CODE_W-1:0] code);
    case (code)
      ALU_ADD, ALU_ADDI, ALU_SUB, ALU_RSB, ALU_AND, ALU_ORR, ALU_EOR, ALU_BIC,
      ALU_MOV, ALU_MOVI: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  // Compare/test ops: only the flags are updated.
  function automatic logic is_compare(input logic [CODE_W-1:0] code);
    case (code)
      ALU_CMP, ALU_CMN, ALU_TST, ALU_CMPI: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [CODE_W-1:0] code);
    return is_alu_wb(code) || is_compare(code) ||
           code == BR_B || code == BR_BL || code == DT_LDR || code == DT_STR;
  endfunction

  // Ops whose operand B is the immediate/offset field.
  function automatic logic uses_imm(input logic [CODE_W-1:0] code);
    case (code)
      ALU_ADDI, ALU_MOVI, ALU_CMPI, DT_LDR, DT_STR: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - controller to datapath/memory/decoder signal bundle
interface cpu_controller_if;
  import cpu_ctrl_pkg::*;

  logic              imem_req;
  logic              imem_ack;
  logic              ir_write;
  logic              decoder_enable;
  logic [CODE_W-1:0] alu_ctl_code;
  logic              execute_flag;
  logic              alu_src_imm;
  logic              cpsr_write;
  logic              reg_write;
  logic [1:0]        wb_sel;
  logic              link_dst;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              pc_write;
  logic [1:0]        pc_sel;
  logic              illegal;
  logic              timeout_fault;
  logic [31:0]       retired_count;
  logic [2:0]        state;

  modport master (
    output imem_req, ir_write, decoder_enable, alu_src_imm, cpsr_write, reg_write,
           wb_sel, link_dst, dmem_req, dmem_we, pc_write, pc_sel, illegal,
           timeout_fault, retired_count, state,
    input  imem_ack, alu_ctl_code, execute_flag, dmem_ack
  );

  modport slave (
    input  imem_req, ir_write, decoder_enable, alu_src_imm, cpsr_write, reg_write,
           wb_sel, link_dst, dmem_req, dmem_we, pc_write, pc_sel, illegal,
           timeout_fault, retired_count, state,
    output imem_ack, alu_ctl_code, execute_flag, dmem_ack
  );

endinterface

// File: rtl/cpu_controller_wait_timer.sv
// rtl/cpu_controller_wait_timer.sv - memory ack wait counter shared by fetch and data access
module wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [7:0] count;

  // Count unacknowledged wait cycles; cleared whenever the sequencer changes state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (tick)  count <= count + 8'd1;
  end

  // High during the last allowed wait cycle; an ack in that cycle still wins.
  assign expired = (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.master  bus
);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q;
  logic              exec_q;
  logic              illegal_q, timeout_q;
  logic [31:0]       retired_q;

  logic        imem_req, ir_write, decoder_enable, alu_src_imm, cpsr_write, reg_write;
  logic        link_dst, dmem_req, dmem_we, pc_write;
  logic [1:0]  wb_sel, pc_sel;
  logic        skip, set_illegal, set_timeout, in_wait, got_ack;
  logic        tmr_clear, tmr_tick, tmr_expired;

  wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // Next-state and strobe decode; everything is forced to its idle value while reset is held.
  always_comb begin
    state_d        = state_q;
    imem_req       = 1'b0;
    ir_write       = 1'b0;
    decoder_enable = 1'b0;
    alu_src_imm    = 1'b0;
    cpsr_write     = 1'b0;
    reg_write      = 1'b0;
    wb_sel         = WB_ALU;
    link_dst       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    pc_write       = 1'b0;
    pc_sel         = PC_SEL_SEQ;
    skip           = 1'b0;
    set_illegal    = 1'b0;
    set_timeout    = 1'b0;
    in_wait        = 1'b0;
    got_ack        = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          in_wait  = 1'b1;
          got_ack  = bus.imem_ack;
          if (bus.imem_ack) begin
            ir_write = 1'b1;
            state_d  = ST_DECODE;
          end else if (tmr_expired) begin
            set_timeout = 1'b1;
            state_d     = ST_FAULT;
          end
        end
        ST_DECODE: begin
          decoder_enable = 1'b1;
          if (!bus.execute_flag) begin
            pc_write = 1'b1;
            skip     = 1'b1;
            state_d  = ST_FETCH;
          end else if (!is_legal(bus.alu_ctl_code)) begin
            set_illegal = 1'b1;
            state_d     = ST_FAULT;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_src_imm = exec_q && uses_imm(code_q);
          if (is_alu_wb(code_q)) begin
            state_d = ST_WB;
          end else if (is_compare(code_q)) begin
            cpsr_write = 1'b1;
            pc_write   = 1'b1;
            state_d    = ST_FETCH;
          end else if (code_q == BR_B) begin
            pc_write = 1'b1;
            pc_sel   = PC_SEL_BR;
            state_d  = ST_FETCH;
          end else if (code_q == BR_BL) begin
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
            link_dst  = 1'b1;
            pc_write  = 1'b1;
            pc_sel    = PC_SEL_BR;
            state_d   = ST_FETCH;
          end else if (code_q == DT_LDR || code_q == DT_STR) begin
            state_d = ST_MEM;
          end else begin
            set_illegal = 1'b1;
            state_d     = ST_FAULT;
          end
        end
        ST_MEM: begin
          alu_src_imm = exec_q && uses_imm(code_q);
          dmem_req    = 1'b1;
          dmem_we     = (code_q == DT_STR);
          in_wait     = 1'b1;
          got_ack     = bus.dmem_ack;
          if (bus.dmem_ack) begin
            if (code_q == DT_STR) begin
              pc_write = 1'b1;
              state_d  = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (tmr_expired) begin
            set_timeout = 1'b1;
            state_d     = ST_FAULT;
          end
        end
        ST_WB: begin
          alu_src_imm = exec_q && uses_imm(code_q);
          reg_write   = 1'b1;
          wb_sel      = (code_q == DT_LDR) ? WB_MEM : WB_ALU;
          pc_write    = 1'b1;
          state_d     = ST_FETCH;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign tmr_tick  = in_wait && !got_ack;
  assign tmr_clear = (state_d != state_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Capture the decoder result so EXEC onward no longer depends on live decoder inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= '0;
      exec_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      code_q <= bus.alu_ctl_code;
      exec_q <= bus.execute_flag;
    end
  end

  // Sticky fault flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Retired-instruction counter: every PC update except a condition-failed skip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                retired_q <= '0;
    else if (pc_write && !skip) retired_q <= retired_q + 32'd1;
  end

  assign bus.imem_req       = imem_req;
  assign bus.ir_write       = ir_write;
  assign bus.decoder_enable = decoder_enable;
  assign bus.alu_src_imm    = alu_src_imm;
  assign bus.cpsr_write     = cpsr_write;
  assign bus.reg_write      = reg_write;
  assign bus.wb_sel         = wb_sel;
  assign bus.link_dst       = link_dst;
  assign bus.dmem_req       = dmem_req;
  assign bus.dmem_we        = dmem_we;
  assign bus.pc_write       = pc_write;
  assign bus.pc_sel         = pc_sel;
  assign bus.illegal        = illegal_q;
  assign bus.timeout_fault  = timeout_q;
  assign bus.retired_count  = retired_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized check of cpu_controller against a per-instruction reference model
module tb_cpu_controller;
  import cpu_ctrl_pkg::*;

  localparam int T = 16;

  typedef struct {
    int len;
    bit fault_ill;
    bit fault_to;
    int n_ireq, n_ir, n_dec, n_cpsr, n_reg, n_link, n_pcw, n_dreq, n_we, n_imm, n_combo;
    int wb;
    int pcs;
    int retire;
  } exp_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    model_retired = 0;
  string ctx = "init";

  cpu_controller_if bus();

  cpu_controller #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d", ctx, tag, got, exp);
  endtask

  function automatic logic [13:0] strobes();
    return {bus.imem_req, bus.ir_write, bus.decoder_enable, bus.alu_src_imm, bus.cpsr_write,
            bus.reg_write, bus.link_dst, bus.dmem_req, bus.dmem_we, bus.pc_write,
            bus.wb_sel, bus.pc_sel};
  endfunction

  function automatic bit m_alu(input int c);
    return (c >= 0 && c <= 7) || c == 11 || c == 12;
  endfunction
  function automatic bit m_cmp(input int c);
    return (c >= 8 && c <= 10) || c == 13;
  endfunction
  function automatic bit m_legal(input int c);
    return (c >= 0 && c <= 13) || c == 31 || c == 32 || c == 41 || c == 42;
  endfunction
  function automatic bit m_imm(input int c);
    return c == 1 || c == 12 || c == 13 || c == 41 || c == 42;
  endfunction

  // Whole-instruction expectation: cycle count, strobe tallies, select values, faults.
  function automatic exp_t model(input int code, input bit flag, input int iw, input int dw);
    exp_t e;
    int   mc;
    e = '{default: 0};
    if (iw >= T) begin
      e.len = T; e.n_ireq = T; e.fault_to = 1;
      return e;
    end
    e.n_ireq = iw + 1; e.n_ir = 1; e.n_dec = 1; e.len = iw + 2;
    if (!flag) begin
      e.n_pcw = 1; e.pcs = 0;
      return e;
    end
    if (!m_legal(code)) begin
      e.fault_ill = 1;
      return e;
    end
    e.retire = 1;
    if (m_alu(code)) begin
      e.len += 2; e.n_reg = 1; e.wb = 0; e.n_pcw = 1; e.n_imm = m_imm(code) ? 2 : 0;
    end else if (m_cmp(code)) begin
      e.len += 1; e.n_cpsr = 1; e.n_pcw = 1; e.n_imm = m_imm(code) ? 1 : 0;
    end else if (code == 31) begin
      e.len += 1; e.n_pcw = 1; e.pcs = 1;
    end else if (code == 32) begin
      e.len += 1; e.n_reg = 1; e.wb = 2; e.n_link = 1; e.n_pcw = 1; e.pcs = 1; e.n_combo = 1;
    end else begin
      mc = (dw < T) ? dw + 1 : T;
      e.len += 1 + mc; e.n_dreq = mc; e.n_we = (code == 42) ? mc : 0; e.n_imm = 1 + mc;
      if (dw >= T) begin
        e.fault_to = 1; e.retire = 0;
      end else begin
        e.n_pcw = 1;
        if (code == 41) begin
          e.len += 1; e.n_reg = 1; e.wb = 1; e.n_imm += 1;
        end
      end
    end
    return e;
  endfunction

  // Drive one instruction: memories ack after iw/dw request cycles, stale acks and decoder
  // junk appear elsewhere. cut>0 stops early without checking. Returns whether a fault is expected.
  task automatic run_instr(input int code, input bit flag, input int iw, input int dw,
                           input int cut, output bit faulted);
    exp_t e;
    int len, ireq_n, dreq_n;
    int t_ireq, t_ir, t_dec, t_cpsr, t_reg, t_link, t_pcw, t_dreq, t_we, t_imm, t_combo;
    int g_wb, g_pcs;
    bit dec_seen;
    e = model(code, flag, iw, dw);
    len = (cut > 0) ? cut : e.len;
    ireq_n = 0; dreq_n = 0; dec_seen = 0;
    t_ireq = 0; t_ir = 0; t_dec = 0; t_cpsr = 0; t_reg = 0; t_link = 0; t_pcw = 0;
    t_dreq = 0; t_we = 0; t_imm = 0; t_combo = 0; g_wb = -1; g_pcs = -1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (bus.imem_req) bus.imem_ack = (ireq_n == iw);
      else              bus.imem_ack = 1'($urandom_range(0, 1));
      if (bus.dmem_req) bus.dmem_ack = (dreq_n == dw);
      else              bus.dmem_ack = 1'($urandom_range(0, 1));
      if (!dec_seen) begin
        bus.alu_ctl_code = 11'(code);
        bus.execute_flag = flag;
      end else begin
        bus.alu_ctl_code = 11'($urandom);
        bus.execute_flag = 1'($urandom_range(0, 1));
      end
      #1;
      if (bus.imem_req)       begin t_ireq++; ireq_n++; end
      if (bus.dmem_req)       begin t_dreq++; dreq_n++; end
      if (bus.ir_write)       t_ir++;
      if (bus.decoder_enable) begin t_dec++; dec_seen = 1; end
      if (bus.cpsr_write)     t_cpsr++;
      if (bus.reg_write)      begin t_reg++; g_wb = int'(bus.wb_sel); end
      if (bus.link_dst)       t_link++;
      if (bus.pc_write)       begin t_pcw++; g_pcs = int'(bus.pc_sel); end
      if (bus.dmem_we)        t_we++;
      if (bus.alu_src_imm)    t_imm++;
      if (bus.reg_write && bus.pc_write && bus.link_dst && bus.pc_sel == 2'd1 && bus.wb_sel == 2'd2)
        t_combo++;
    end
    faulted = e.fault_ill || e.fault_to;
    if (cut == 0) begin
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (!faulted) model_retired += e.retire;
      check("imem_req cycles", 32'(t_ireq), 32'(e.n_ireq));
      check("ir_write", 32'(t_ir), 32'(e.n_ir));
      check("decoder_enable", 32'(t_dec), 32'(e.n_dec));
      check("cpsr_write", 32'(t_cpsr), 32'(e.n_cpsr));
      check("reg_write", 32'(t_reg), 32'(e.n_reg));
      check("link_dst", 32'(t_link), 32'(e.n_link));
      check("pc_write", 32'(t_pcw), 32'(e.n_pcw));
      check("dmem_req cycles", 32'(t_dreq), 32'(e.n_dreq));
      check("dmem_we cycles", 32'(t_we), 32'(e.n_we));
      check("alu_src_imm cycles", 32'(t_imm), 32'(e.n_imm));
      check("bl same-cycle", 32'(t_combo), 32'(e.n_combo));
      if (e.n_reg > 0) check("wb_sel", 32'(g_wb), 32'(e.wb));
      if (e.n_pcw > 0) check("pc_sel", 32'(g_pcs), 32'(e.pcs));
      check("state after", 32'(bus.state), faulted ? 32'(ST_FAULT) : 32'(ST_FETCH));
      check("imem_req after", 32'(bus.imem_req), faulted ? 32'd0 : 32'd1);
      check("retired_count", bus.retired_count, 32'(model_retired));
      check("illegal", 32'(bus.illegal), 32'(e.fault_ill));
      check("timeout_fault", 32'(bus.timeout_fault), 32'(e.fault_to));
    end
  endtask

  task automatic hold_fault(input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.imem_ack     = 1'($urandom_range(0, 1));
      bus.dmem_ack     = 1'($urandom_range(0, 1));
      bus.alu_ctl_code = 11'($urandom);
      bus.execute_flag = 1'($urandom_range(0, 1));
      #1;
      if (strobes() != 14'd0 || bus.state != 3'(ST_FAULT)) bad++;
    end
    check("fault hold violations", 32'(bad), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    reset = 1'b0;
    #1;
    check("first imem_req", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset strobes", 32'(strobes()), 32'd0);
    check("reset state", 32'(bus.state), 32'(ST_FETCH));
    check("reset retired", bus.retired_count, 32'd0);
    check("reset faults", 32'({bus.illegal, bus.timeout_fault}), 32'd0);
    model_retired = 0;
    @(posedge clk);
    release_reset();
  endtask

  initial begin
    int legal_list[18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 31, 32, 41, 42};
    bit f;
    int code, iw, dw, r;
    bit flag;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.alu_ctl_code = '0;
    bus.execute_flag = 1'b0;
    #1;
    ctx = "power-on";
    check("reset strobes", 32'(strobes()), 32'd0);
    check("reset state", 32'(bus.state), 32'(ST_FETCH));
    check("reset retired", bus.retired_count, 32'd0);
    @(posedge clk);
    release_reset();

    ctx = "ADD";        run_instr(0, 1, 0, 0, 0, f);
    ctx = "CMP";        run_instr(8, 1, 0, 0, 0, f);
    ctx = "cond fail";  run_instr(0, 0, 0, 0, 0, f);
    ctx = "BL";         run_instr(32, 1, 0, 0, 0, f);
    ctx = "B";          run_instr(31, 1, 2, 0, 0, f);
    ctx = "LDR wait2";  run_instr(41, 1, 0, 2, 0, f);
    ctx = "STR ack0";   run_instr(42, 1, 0, 0, 0, f);
    ctx = "fetch last"; run_instr(12, 1, T - 1, 0, 0, f);
    ctx = "LDR last";   run_instr(41, 1, 1, T - 1, 0, f);
    ctx = "STR timeout"; run_instr(42, 1, 0, T, 0, f);
    hold_fault(3);
    do_reset();
    ctx = "illegal 20"; run_instr(20, 1, 0, 0, 0, f);
    hold_fault(50);
    do_reset();
    ctx = "fetch timeout"; run_instr(0, 1, T, 0, 0, f);
    hold_fault(3);
    do_reset();

    ctx = "pre mid-MEM"; run_instr(13, 1, 0, 0, 0, f);
    ctx = "mid-MEM";     run_instr(42, 1, 0, T, 4, f);
    check("in MEM before reset", 32'(bus.dmem_req), 32'd1);
    do_reset();

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) code = ($urandom_range(0, 1) == 0) ? $urandom_range(14, 30) : $urandom_range(43, 2047);
      else        code = legal_list[$urandom_range(0, 17)];
      flag = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 19);
      iw = (r == 0) ? T : (r == 1) ? T - 1 : $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      dw = (r == 0) ? T : (r == 1) ? T - 1 : $urandom_range(0, 3);
      ctx = $sformatf("rand%0d code%0d flag%0d iw%0d dw%0d", i, code, flag, iw, dw);
      run_instr(code, flag, iw, dw, 0, f);
      if (f) begin
        hold_fault(3);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control sequencer for the single-issue ARM-subset CPU. It steps each instruction through fetch, decode, execute, memory and writeback. It gates the combinational instruction decoder through `decoder_enable` and consumes the decoder's `ALUCtl_code` and `execute_flag`. It drives every register-file, CPSR, PC and memory strobe in the datapath, and counts retired instructions.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum wait cycles for `imem_ack` or `dmem_ack` before a fault; legal range 2–255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch data valid on the IR input this cycle.
- `ir_write`  out  1  load the instruction register.
- `decoder_enable`  out  1  enable for the instruction decoder.
- `alu_ctl_code`  in  11  decoder operation code.
- `execute_flag`  in  1  decoder condition-pass result.
- `alu_src_imm`  out  1  ALU operand B is the immediate or offset, not `rm`.
- `cpsr_write`  out  1  update the NZCV flags.
- `reg_write`  out  1  register-file write.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4.
- `link_dst`  out  1  force the write destination to R14.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  store (1) or load (0); valid while `dmem_req` is high.
- `dmem_ack`  in  1  data memory transfer complete.
- `pc_write`  out  1  PC update.
- `pc_sel`  out  2  0 = PC+4, 1 = branch target.
- `illegal`  out  1  sticky: an undefined code was decoded.
- `timeout_fault`  out  1  sticky: a memory ack wait expired.
- `retired_count`  out  32  count of executed instructions; wraps modulo 2^32.
- `state`  out  3  current FSM state, for debug.

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, FAULT.

- **FETCH**
  - `imem_req`=1.
  - On `imem_ack`: `ir_write`=1, next state DECODE.
- **DECODE**
  - `decoder_enable`=1.
  - Register `alu_ctl_code` and `execute_flag` into internal latches.
  - If `execute_flag`=0: `pc_write`=1, `pc_sel`=0, next state FETCH. The skipped instruction is not counted.
  - Else if the code is not in {0–13, 31, 32, 41, 42}: next state FAULT with `illegal` set.
  - Else: next state EXEC.
- **EXEC** (acts on the latched code)
  - Codes 0–7, 11, 12: next state WB.
  - Codes 8, 9, 10, 13 (compare/test): `cpsr_write`=1, `pc_write`=1 with `pc_sel`=0, next state FETCH.
  - Code 31 (B): `pc_write`=1, `pc_sel`=1, next state FETCH.
  - Code 32 (BL): `reg_write`=1, `wb_sel`=2, `link_dst`=1, `pc_write`=1, `pc_sel`=1, next state FETCH.
  - Codes 41, 42 (LDR/STR): next state MEM.
- **`alu_src_imm`**: 1 in EXEC, MEM and WB when the code is 1, 12, 13, 41 or 42; otherwise 0.
- **MEM**
  - `dmem_req`=1; `dmem_we`=1 for code 42.
  - On `dmem_ack` for LDR: next state WB.
  - On `dmem_ack` for STR: `pc_write`=1, `pc_sel`=0, next state FETCH.
- **WB**
  - `reg_write`=1; `wb_sel`=1 for LDR, 0 otherwise.
  - `pc_write`=1, `pc_sel`=0, next state FETCH.
- **FAULT**
  - All strobes are 0.
  - The state is held until `reset`.
- **Retired count**: `retired_count` increments by 1 on every `pc_write` except the DECODE skip path.
- **Wait timeout**: a wait counter clears on entry to FETCH or MEM and increments each cycle without an ack.
  - Reaching `MEM_TIMEOUT` cycles without an ack moves to FAULT with `timeout_fault` set.
  - The request drops in the FAULT cycle.

## Timing
- **Reset values**: state FETCH, all strobes 0, `wb_sel`/`pc_sel` 0, `illegal`/`timeout_fault` 0, `retired_count` 0, code latches 0.
- **First request**: `imem_req` is 1 in the first cycle after `reset` deasserts.
- **Output decoding**: strobes are Moore outputs decoded from the state and the latched code, and are never combinational from an ack.
  - Exceptions: `ir_write` and the MEM→FETCH `pc_write` qualify on the ack in the same cycle.
  - `decoder_enable` and the DECODE-cycle decisions use the live decoder inputs.
- **Latency with zero-wait acks**:
  - ALU op: 4 cycles.
  - Compare, B, BL: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Skipped instruction: 2 cycles.
- **Ack and timeout together**: an ack in the final (`MEM_TIMEOUT`-th) wait cycle wins over the timeout.
- **Stale acks**: an ack arriving outside the matching wait state is ignored.
- **Strobe width**: each strobe is high for exactly one cycle per instruction, except requests, which stay high until ack or timeout.
- **Reset mid-instruction** (any state, including MEM):
  - All outputs return to their reset values immediately (asynchronous).
  - No partial write occurs after reset asserts.
  - Faults and the counter clear.

## Structure
- **Package `cpu_ctrl_pkg`**:
  - State enum.
  - Named `ALUCtl_code` constants (`ALU_ADD`=0 … `ALU_CMPI`=13, `BR_B`=31, `BR_BL`=32, `DT_LDR`=41, `DT_STR`=42).
  - `wb_sel` and `pc_sel` encodings.
- **Sub-module `wait_timer`**: parameterised `MEM_TIMEOUT` counter with `clear`/`tick` inputs and an `expired` output. It is shared by FETCH and MEM.

## Test plan
- **ADD**: code 0, `execute_flag`=1, `imem_ack` on the first FETCH cycle → states FETCH, DECODE, EXEC, WB; WB has `reg_write`=1, `wb_sel`=0, `pc_write`=1, `pc_sel`=0; `retired_count` goes 0→1.
- **CMP**: code 8 → EXEC has `cpsr_write`=1 and `pc_write` with `pc_sel`=0; `reg_write` never asserts.
- **Condition fail**: `execute_flag`=0 with code 0 → DECODE has `pc_write`=1, `pc_sel`=0; no reg, CPSR or memory strobe; `retired_count` unchanged.
- **BL**: code 32 → EXEC has `reg_write`=1, `wb_sel`=2, `link_dst`=1, `pc_write`=1, `pc_sel`=1, all in the same cycle.
- **LDR and STR timeout**:
  - LDR (code 41) with `dmem_ack` arriving in the 3rd MEM cycle → `dmem_req` high for 3 cycles with `dmem_we`=0, then WB with `wb_sel`=1.
  - STR (code 42) with no ack → FAULT after 16 MEM cycles, `timeout_fault`=1, `dmem_req`=0.
- **Illegal code and reset**:
  - Code 20 → FAULT, `illegal`=1, held for 50 cycles.
  - Assert `reset` in FAULT, or mid-MEM → state FETCH, all outputs at reset values.
